sync_fifo_rv: RTL and testbench

Parametrised synchronous FIFO with valid/ready handshakes on both sides, first-word-fall-through read data, an occupancy count, programmable almost-full/almost-empty flags, synchronous flush and a sticky drop counter. It buffers operand words between the input staging logic and the GCD datapath. It is the general replacement for the fixed 8-deep, enable-driven FIFO, which supported power-of-two depth only and had a registered, pop-latency read port.

---
 rtl/fifo_pkg.sv | 10 +
 rtl/fifo_mem.sv | 28 ++
 rtl/sync_fifo_rv.sv | 111 +++++++++++
 tb/tb_sync_fifo_rv.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the valid/ready synchronous FIFO.
package fifo_pkg;

  localparam int unsigned DROP_W = 8;

  function automatic int unsigned CNT_W(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH storage with one synchronous write port and a combinational read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned PTR_W      = 3
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [PTR_W-1:0]      waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [PTR_W-1:0]      raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Storage is deliberately left unreset; emptiness is tracked by the count.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_rv.sv
// First-word-fall-through FIFO with valid/ready ports, occupancy flags, flush and drop counter.
module sync_fifo_rv
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned AF_LEVEL   = DEPTH - 1,
  parameter int unsigned AE_LEVEL   = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  logic                      wr_valid_i,
  output logic                      wr_ready_o,
  input  logic [DATA_WIDTH-1:0]     wr_data_i,
  output logic                      rd_valid_o,
  input  logic                      rd_ready_i,
  output logic [DATA_WIDTH-1:0]     rd_data_o,
  output logic [CNT_W(DEPTH)-1:0]   count_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic                      almost_full_o,
  output logic                      almost_empty_o,
  output logic [DROP_W-1:0]         drop_cnt_o
);

  localparam int unsigned CntW = CNT_W(DEPTH);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [PtrW-1:0]   PtrMax  = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0]   CntFull = CntW'(DEPTH);
  localparam logic [CntW-1:0]   CntAf   = CntW'(AF_LEVEL);
  localparam logic [CntW-1:0]   CntAe   = CntW'(AE_LEVEL);
  localparam logic [DROP_W-1:0] DropMax = '1;

  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [DROP_W-1:0]     drop_q, drop_d;
  logic                  full, empty, push, pop;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign full  = (count_q == CntFull);
  assign empty = (count_q == '0);
  assign push  = wr_valid_i & ~full;
  assign pop   = rd_ready_i & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = (wr_ptr_q == PtrMax) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == PtrMax) ? '0 : rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CntW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CntW'(1);
      end
      if (wr_valid_i && full && drop_q != DropMax) begin
        drop_d = drop_q + DROP_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .PTR_W      (PtrW)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (push & ~flush_i),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  assign wr_ready_o     = ~full;
  assign rd_valid_o     = ~empty;
  assign rd_data_o      = empty ? '0 : mem_rdata;
  assign count_o        = count_q;
  assign full_o         = full;
  assign empty_o        = empty;
  assign almost_full_o  = (count_q >= CntAf);
  assign almost_empty_o = (count_q <= CntAe);
  assign drop_cnt_o     = drop_q;

endmodule

// File: tb/tb_sync_fifo_rv.sv
// Directed and randomized checks of sync_fifo_rv against a queue-based reference model.
module tb_sync_fifo_rv;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 6;
  localparam int unsigned AF    = 4;
  localparam int unsigned AE    = 1;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          flush_i, wr_valid_i, rd_ready_i;
  logic [DW-1:0] wr_data_i;
  logic          wr_ready_o, rd_valid_o, full_o, empty_o, almost_full_o, almost_empty_o;
  logic [DW-1:0] rd_data_o;
  logic [CW-1:0] count_o;
  logic [7:0]    drop_cnt_o;

  int vectors    = 0;
  int miscompares = 0;

  logic [DW-1:0] model_q[$];
  int            model_drops = 0;

  always #5 clk_i = ~clk_i;

  sync_fifo_rv #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_LEVEL   (AF),
    .AE_LEVEL   (AE)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .wr_valid_i     (wr_valid_i),
    .wr_ready_o     (wr_ready_o),
    .wr_data_i      (wr_data_i),
    .rd_valid_o     (rd_valid_o),
    .rd_ready_i     (rd_ready_i),
    .rd_data_o      (rd_data_o),
    .count_o        (count_o),
    .full_o         (full_o),
    .empty_o        (empty_o),
    .almost_full_o  (almost_full_o),
    .almost_empty_o (almost_empty_o),
    .drop_cnt_o     (drop_cnt_o)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all(input string step);
    int n;
    n = model_q.size();
    chk({step, ":count"},    int'(count_o),        n);
    chk({step, ":full"},     int'(full_o),         int'(n == DEPTH));
    chk({step, ":empty"},    int'(empty_o),        int'(n == 0));
    chk({step, ":wr_ready"}, int'(wr_ready_o),     int'(n != DEPTH));
    chk({step, ":rd_valid"}, int'(rd_valid_o),     int'(n != 0));
    chk({step, ":rd_data"},  int'(rd_data_o),      (n != 0) ? int'(model_q[0]) : 0);
    chk({step, ":afull"},    int'(almost_full_o),  int'(n >= AF));
    chk({step, ":aempty"},   int'(almost_empty_o), int'(n <= AE));
    chk({step, ":drops"},    int'(drop_cnt_o),     model_drops);
  endtask

  // One clock: drive inputs, advance the model by the handshake rules, check after the edge.
  task automatic cyc(input string step, input logic wv, input logic [DW-1:0] wd,
                     input logic rr, input logic fl);
    bit was_full, do_push, do_pop;
    wr_valid_i = wv;
    wr_data_i  = wd;
    rd_ready_i = rr;
    flush_i    = fl;
    was_full   = (model_q.size() == DEPTH);
    if (fl) begin
      model_q.delete();
    end else begin
      do_push = wv && !was_full;
      do_pop  = rr && (model_q.size() != 0);
      if (wv && was_full && model_drops < 255) model_drops++;
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back(wd);
    end
    @(posedge clk_i);
    #1;
    check_all(step);
  endtask

  initial begin
    rst_ni     = 1'b0;
    flush_i    = 1'b0;
    wr_valid_i = 1'b0;
    rd_ready_i = 1'b0;
    wr_data_i  = '0;
    #3;
    check_all("reset");
    #9 rst_ni = 1'b1;

    // Fill without reading; head visible one cycle after first push.
    for (int i = 0; i < 5; i++) cyc("fill", 1'b1, DW'(8'h11 + i), 1'b0, 1'b0);
    cyc("to_full", 1'b1, 8'h16, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc("drop", 1'b1, 8'hEE, 1'b0, 1'b0);
    cyc("full_push_pop", 1'b1, 8'hAA, 1'b1, 1'b0);
    cyc("refill", 1'b1, 8'h20, 1'b0, 1'b0);

    // Wrap across the non-power-of-two boundary.
    for (int i = 0; i < 3; i++) cyc("wrap_pop", 1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc("wrap_push", 1'b1, DW'(8'h21 + i), 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cyc("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    cyc("empty_pop", 1'b0, 8'h00, 1'b1, 1'b0);

    // Half-full streaming.
    for (int i = 0; i < 3; i++) cyc("half", 1'b1, DW'(8'h30 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc("stream", 1'b1, DW'($urandom), 1'b1, 1'b0);

    // Flush beats a simultaneous push and pop; a write against full during flush is no drop.
    cyc("flush_rw", 1'b1, 8'h55, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) cyc("fill2", 1'b1, DW'(8'h40 + i), 1'b0, 1'b0);
    cyc("flush_full", 1'b1, 8'h66, 1'b0, 1'b1);

    // Asynchronous reset mid-burst at count 4.
    for (int i = 0; i < 4; i++) cyc("burst", 1'b1, DW'(8'h50 + i), 1'b0, 1'b0);
    wr_valid_i = 1'b1;
    rst_ni     = 1'b0;
    model_q.delete();
    model_drops = 0;
    #1;
    check_all("async_rst");
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    cyc("post_rst_push", 1'b1, 8'h77, 1'b0, 1'b0);
    cyc("post_rst_pop", 1'b0, 8'h00, 1'b1, 1'b0);

    // Drop counter saturation.
    for (int i = 0; i < 6; i++) cyc("fill3", 1'b1, DW'(8'h60 + i), 1'b0, 1'b0);
    for (int i = 0; i < 258; i++) begin
      wr_valid_i = 1'b1;
      cyc("saturate", 1'b1, 8'hFF, 1'b0, 1'b0);
    end

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cyc("random", 1'($urandom_range(0, 2) != 0), DW'($urandom), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 40) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
